// File: rtl/map_mem_arb_pkg.sv
// Shared definitions for the ROM1 port arbiter: FSM state encoding and timer width helper.
package map_mem_arb_pkg;

    localparam int BW_ARB_ST = 2;

    typedef enum logic [BW_ARB_ST-1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_HOLD = 2'd2,
        ARB_MCU  = 2'd3
    } arb_st_e;

    function automatic int cycCntW(input int memCyc);
        return $clog2(memCyc) + 1;
    endfunction

endpackage

// File: rtl/map_mem_arb_tmr.sv
// Fixed-length memory access timer shared by the CPU and MCU access states.
// A start pulse opens a window of MEM_CYC cycles; last_o marks its final cycle.
module map_arb_tmr
    import map_mem_arb_pkg::*;
#(
    parameter int MEM_CYC = 4
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic start_i,
    output logic busy_o,
    output logic last_o
);

    localparam int CW = cycCntW(MEM_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == CW'(MEM_CYC - 1));

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (last_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(negedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/map_mem_arb.sv
// Arbiter for the single ROM1 port between the 68k cartridge bus and the MCU transfer port.
// Optional stall statistics counter enabled by defining MAP_ARB_STAT_EN.
module map_mem_arb
    import map_mem_arb_pkg::*;
#(
    parameter int MEM_CYC = 4,
    parameter int AW      = 23
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we_lo,
    input  logic          cpu_we_hi,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_di,
    output logic [15:0]   cpu_do,
    output logic          cpu_dtack,
    input  logic          mcu_req,
    input  logic          mcu_we,
    input  logic [1:0]    mcu_be,
    input  logic [AW-1:0] mcu_addr,
    input  logic [15:0]   mcu_di,
    output logic [15:0]   mcu_do,
    output logic          mcu_ack,
`ifdef MAP_ARB_STAT_EN
    input  logic          stat_clr,
    output logic [15:0]   stat_stall,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_di,
    input  logic [15:0]   mem_do,
    output logic          mem_oe,
    output logic          mem_we_lo,
    output logic          mem_we_hi
);

    arb_st_e       state_q, state_d;
    logic          lastCpu_q, lastCpu_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          weLo_q, weLo_d;
    logic          weHi_q, weHi_d;
    logic          rd_q, rd_d;
    logic [15:0]   cpuDo_q, cpuDo_d;
    logic [15:0]   mcuDo_q, mcuDo_d;
    logic          cpuDtack_q, cpuDtack_d;
    logic          mcuAck_q, mcuAck_d;
    logic          tmrStart, tmrBusy, tmrLast;
    logic          accActive;

    map_arb_tmr #(.MEM_CYC(MEM_CYC)) u_tmr (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .start_i  (tmrStart),
        .busy_o   (tmrBusy),
        .last_o   (tmrLast)
    );

    // Strobes are decoded from state so an async reset drops them immediately.
    assign accActive = ((state_q == ARB_CPU) || (state_q == ARB_MCU)) && tmrBusy;
    assign mem_oe    = accActive && rd_q;
    assign mem_we_lo = accActive && weLo_q;
    assign mem_we_hi = accActive && weHi_q;
    assign mem_addr  = addr_q;
    assign mem_di    = data_q;
    assign cpu_do    = cpuDo_q;
    assign mcu_do    = mcuDo_q;
    assign cpu_dtack = cpuDtack_q;
    assign mcu_ack   = mcuAck_q;

    always_comb begin
        state_d    = state_q;
        lastCpu_d  = lastCpu_q;
        addr_d     = addr_q;
        data_d     = data_q;
        weLo_d     = weLo_q;
        weHi_d     = weHi_q;
        rd_d       = rd_q;
        cpuDo_d    = cpuDo_q;
        mcuDo_d    = mcuDo_q;
        cpuDtack_d = cpuDtack_q;
        mcuAck_d   = 1'b0;
        tmrStart   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // On contention the requester not served last wins.
                if (cpu_req && !(mcu_req && lastCpu_q)) begin
                    state_d   = ARB_CPU;
                    lastCpu_d = 1'b1;
                    addr_d    = cpu_addr;
                    data_d    = cpu_di;
                    weLo_d    = cpu_we_lo;
                    weHi_d    = cpu_we_hi;
                    rd_d      = !(cpu_we_lo || cpu_we_hi);
                    tmrStart  = 1'b1;
                end else if (mcu_req) begin
                    state_d   = ARB_MCU;
                    lastCpu_d = 1'b0;
                    addr_d    = mcu_addr;
                    data_d    = mcu_di;
                    weLo_d    = mcu_we && mcu_be[0];
                    weHi_d    = mcu_we && mcu_be[1];
                    rd_d      = !mcu_we;
                    tmrStart  = 1'b1;
                end
            end
            ARB_CPU: begin
                if (tmrLast) begin
                    if (rd_q) cpuDo_d = mem_do;
                    cpuDtack_d = 1'b1;
                    state_d    = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                // Waiting here keeps one bus cycle from triggering a second access.
                if (!cpu_req) begin
                    cpuDtack_d = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end
            ARB_MCU: begin
                if (tmrLast) begin
                    if (rd_q) mcuDo_d = mem_do;
                    mcuAck_d = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ARB_IDLE;
            lastCpu_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            weLo_q     <= 1'b0;
            weHi_q     <= 1'b0;
            rd_q       <= 1'b0;
            cpuDo_q    <= '0;
            mcuDo_q    <= '0;
            cpuDtack_q <= 1'b0;
            mcuAck_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lastCpu_q  <= lastCpu_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            weLo_q     <= weLo_d;
            weHi_q     <= weHi_d;
            rd_q       <= rd_d;
            cpuDo_q    <= cpuDo_d;
            mcuDo_q    <= mcuDo_d;
            cpuDtack_q <= cpuDtack_d;
            mcuAck_q   <= mcuAck_d;
        end
    end

`ifdef MAP_ARB_STAT_EN
    logic [15:0] stall_q, stall_d;

    // Counts clocks where the CPU wants the bus but no CPU access is in flight.
    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = '0;
        end else if (cpu_req && ((state_q == ARB_IDLE) || (state_q == ARB_MCU))
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(negedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) stall_q <= '0;
        else            stall_q <= stall_d;
    end

    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_map_mem_arb.sv
// Self-checking bench for map_mem_arb: directed table, corner sequences, randomized traffic
// against a transaction-level memory/arbitration model. Stat checks only with MAP_ARB_STAT_EN.
module tb_map_mem_arb;

    localparam int MEM_CYC = 4;
    localparam int AW      = 23;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          cpu_req, cpu_we_lo, cpu_we_hi;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_di, cpu_do;
    logic          cpu_dtack;
    logic          mcu_req, mcu_we;
    logic [1:0]    mcu_be;
    logic [AW-1:0] mcu_addr;
    logic [15:0]   mcu_di, mcu_do;
    logic          mcu_ack;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_di;
    logic [15:0]   mem_do = 16'h0000;
    logic          mem_oe, mem_we_lo, mem_we_hi;
`ifdef MAP_ARB_STAT_EN
    logic          stat_clr;
    logic [15:0]   stat_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    map_mem_arb #(.MEM_CYC(MEM_CYC), .AW(AW)) dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .cpu_req  (cpu_req),
        .cpu_we_lo(cpu_we_lo),
        .cpu_we_hi(cpu_we_hi),
        .cpu_addr (cpu_addr),
        .cpu_di   (cpu_di),
        .cpu_do   (cpu_do),
        .cpu_dtack(cpu_dtack),
        .mcu_req  (mcu_req),
        .mcu_we   (mcu_we),
        .mcu_be   (mcu_be),
        .mcu_addr (mcu_addr),
        .mcu_di   (mcu_di),
        .mcu_do   (mcu_do),
        .mcu_ack  (mcu_ack),
`ifdef MAP_ARB_STAT_EN
        .stat_clr  (stat_clr),
        .stat_stall(stat_stall),
`endif
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_do   (mem_do),
        .mem_oe   (mem_oe),
        .mem_we_lo(mem_we_lo),
        .mem_we_hi(mem_we_hi)
    );

    // Power-on contents of the memory, shared by the device model and the reference.
    function automatic logic [15:0] initVal(input logic [AW-1:0] a);
        if (a == 23'h7C0010) return 16'hA55A;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    logic [15:0] devMem [int];
    logic [15:0] devWord;

    always @(posedge clk) begin
        if (mem_we_lo || mem_we_hi) begin
            devWord = devMem.exists(int'(mem_addr)) ? devMem[int'(mem_addr)] : initVal(mem_addr);
            if (mem_we_lo) devWord[7:0]  = mem_di[7:0];
            if (mem_we_hi) devWord[15:8] = mem_di[15:8];
            devMem[int'(mem_addr)] = devWord;
        end
        mem_do = devMem.exists(int'(mem_addr)) ? devMem[int'(mem_addr)] : initVal(mem_addr);
    end

    logic [15:0] refMem [int];

    function automatic logic [15:0] readRef(input logic [AW-1:0] a);
        return refMem.exists(int'(a)) ? refMem[int'(a)] : initVal(a);
    endfunction

    task automatic writeRef(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] w;
        w = readRef(a);
        if (be[0]) w[7:0]  = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        refMem[int'(a)] = w;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CPU requester: called just after a posedge, returns just after the posedge following release.
    task automatic runCpu(input logic weLo, input logic weHi, input logic [AW-1:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat,
                          output int oeC, output int loC, output int hiC, output time doneT);
        bit done = 0;
        lat = 0; oeC = 0; loC = 0; hiC = 0;
        cpu_req = 1'b1; cpu_we_lo = weLo; cpu_we_hi = weHi; cpu_addr = a; cpu_di = d;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            if (cpu_dtack) done = 1;
            else begin
                oeC += int'(mem_oe); loC += int'(mem_we_lo); hiC += int'(mem_we_hi);
            end
        end
        checkOutput("cpu_done", 32'(done), 32'd1);
        rd = cpu_do;
        doneT = $time;
        cpu_req = 1'b0; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0;
        cpu_addr = AW'($urandom); cpu_di = 16'($urandom);
        @(posedge clk);
        checkOutput("cpu_dtack_release", 32'(cpu_dtack), 32'd0);
    endtask

    task automatic runMcu(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat,
                          output int oeC, output int loC, output int hiC, output time doneT);
        bit done = 0;
        lat = 0; oeC = 0; loC = 0; hiC = 0;
        mcu_req = 1'b1; mcu_we = we; mcu_be = be; mcu_addr = a; mcu_di = d;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            if (mcu_ack) done = 1;
            else begin
                oeC += int'(mem_oe); loC += int'(mem_we_lo); hiC += int'(mem_we_hi);
            end
        end
        checkOutput("mcu_done", 32'(done), 32'd1);
        rd = mcu_do;
        doneT = $time;
        mcu_req = 1'b0; mcu_we = 1'b0; mcu_be = 2'b00;
        mcu_addr = AW'($urandom); mcu_di = 16'($urandom);
        @(posedge clk);
        checkOutput("mcu_ack_pulse", 32'(mcu_ack), 32'd0);
    endtask

    typedef struct {
        bit            isMcu;
        bit            we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [15:0]   expRd;
    } vec_t;

    task automatic applyStimulus(input int idx, input vec_t v);
        logic [15:0] r;
        int lat, oeC, loC, hiC;
        time t;
        bit lo, hi, rdOp;
        lo = v.we && v.be[0];
        hi = v.we && v.be[1];
        if (v.isMcu) begin
            rdOp = !v.we;
            runMcu(v.we, v.be, v.addr, v.data, r, lat, oeC, loC, hiC, t);
        end else begin
            rdOp = !(lo || hi);
            runCpu(lo, hi, v.addr, v.data, r, lat, oeC, loC, hiC, t);
        end
        checkOutput($sformatf("row%0d_data", idx), 32'(r), 32'(v.expRd));
        checkOutput($sformatf("row%0d_latency", idx), 32'(lat), 32'(MEM_CYC + 1));
        checkOutput($sformatf("row%0d_oe_cycles", idx), 32'(oeC), rdOp ? 32'(MEM_CYC) : 32'd0);
        checkOutput($sformatf("row%0d_welo_cycles", idx), 32'(loC), lo ? 32'(MEM_CYC) : 32'd0);
        checkOutput($sformatf("row%0d_wehi_cycles", idx), 32'(hiC), hi ? 32'(MEM_CYC) : 32'd0);
    endtask

    vec_t        table_v [8];
    logic [15:0] rA, rB, rM, cR, mR;
    int          latA, latB, latM, cLat, mLat, oA, lA, hA, cOe, cLo, cHi, mOe, mLo, mHi;
    time         tA1, tA2, tM, cT, mT;
    int          oeTot, lat;
    bit          held, ackSeen, dn;
    bit          lastCpu, useCpu, useMcu, cpuFirst, cW, mW;
    logic [1:0]  cBe, mBe;
    logic [AW-1:0] cA, mA;
    logic [15:0] cD, mD, expCpuDo, expMcuDo;
    int          mode;

    initial begin
        table_v[0] = '{1'b0, 1'b0, 2'b00, 23'h7C0010, 16'h0000, 16'hA55A};
        table_v[1] = '{1'b1, 1'b1, 2'b01, 23'h700000, 16'h1234, 16'h0000};
        table_v[2] = '{1'b1, 1'b0, 2'b11, 23'h700000, 16'h0000, 16'hC334};
        table_v[3] = '{1'b0, 1'b1, 2'b10, 23'h700000, 16'hABCD, 16'hA55A};
        table_v[4] = '{1'b0, 1'b0, 2'b00, 23'h700000, 16'h0000, 16'hAB34};
        table_v[5] = '{1'b1, 1'b1, 2'b11, 23'h700005, 16'hBEEF, 16'hC334};
        table_v[6] = '{1'b0, 1'b0, 2'b00, 23'h700005, 16'h0000, 16'hBEEF};
        table_v[7] = '{1'b1, 1'b0, 2'b00, 23'h7C0010, 16'h0000, 16'hA55A};

        sys_rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0; cpu_addr = '0; cpu_di = '0;
        mcu_req = 1'b0; mcu_we = 1'b0; mcu_be = 2'b00; mcu_addr = '0; mcu_di = '0;
`ifdef MAP_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        checkOutput("rst_cpu_do", 32'(cpu_do), 32'd0);
        checkOutput("rst_mcu_do", 32'(mcu_do), 32'd0);
        checkOutput("rst_cpu_dtack", 32'(cpu_dtack), 32'd0);
        checkOutput("rst_mcu_ack", 32'(mcu_ack), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_di", 32'(mem_di), 32'd0);
        checkOutput("rst_mem_oe", 32'(mem_oe), 32'd0);
        checkOutput("rst_mem_we_lo", 32'(mem_we_lo), 32'd0);
        checkOutput("rst_mem_we_hi", 32'(mem_we_hi), 32'd0);
        sys_rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 8; i++) applyStimulus(i, table_v[i]);

        // Contention with MCU served last: CPU first, then MCU beats an immediate second CPU cycle.
        fork
            begin
                runCpu(1'b0, 1'b0, 23'h7C0010, 16'h0, rA, latA, oA, lA, hA, tA1);
                runCpu(1'b0, 1'b0, 23'h700000, 16'h0, rB, latB, oA, lA, hA, tA2);
            end
            runMcu(1'b0, 2'b11, 23'h700005, 16'h0, rM, latM, oA, lA, hA, tM);
        join
        checkOutput("contend_cpu_first", 32'(tA1 < tM), 32'd1);
        checkOutput("contend_mcu_before_cpu2", 32'(tM < tA2), 32'd1);
        checkOutput("contend_cpu1_data", 32'(rA), 32'hA55A);
        checkOutput("contend_cpu2_data", 32'(rB), 32'hAB34);
        checkOutput("contend_mcu_data", 32'(rM), 32'hBEEF);
        checkOutput("contend_cpu2_latency", 32'(latB), 32'(2 * (MEM_CYC + 1)));
        checkOutput("contend_mcu_latency", 32'(latM), 32'(2 * (MEM_CYC + 1) + 1));

        // CPU cycle held for 20 extra clocks: one access only, dtack stays high.
        cpu_req = 1'b1; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0; cpu_addr = 23'h700005;
        oeTot = 0; lat = 0; held = 1;
        while (!cpu_dtack && lat < 100) begin
            @(posedge clk); lat++; oeTot += int'(mem_oe);
        end
        repeat (20) begin
            @(posedge clk); oeTot += int'(mem_oe); held &= cpu_dtack;
        end
        checkOutput("held_dtack_stays", 32'(held), 32'd1);
        checkOutput("held_single_access", 32'(oeTot), 32'(MEM_CYC));
        checkOutput("held_data", 32'(cpu_do), 32'hBEEF);
        cpu_req = 1'b0;
        @(posedge clk);
        checkOutput("held_dtack_release", 32'(cpu_dtack), 32'd0);

        // cpu_req falling mid-access: access completes, dtack lasts a single clock.
        cpu_req = 1'b1; cpu_addr = 23'h7C0010;
        repeat (2) @(posedge clk);
        cpu_req = 1'b0;
        repeat (MEM_CYC - 1) @(posedge clk);
        checkOutput("drop_dtack_high", 32'(cpu_dtack), 32'd1);
        checkOutput("drop_data", 32'(cpu_do), 32'hA55A);
        @(posedge clk);
        checkOutput("drop_dtack_low", 32'(cpu_dtack), 32'd0);

        // Reset during an MCU write aborts it; a CPU request pending over reset is served normally.
        mcu_req = 1'b1; mcu_we = 1'b1; mcu_be = 2'b11; mcu_addr = 23'h700040; mcu_di = 16'h5555;
        @(posedge clk);
        checkOutput("abort_pre_strobe", 32'(mem_we_lo), 32'd1);
        @(posedge clk);
        #1;
        sys_rst_n = 1'b0;
        mcu_req = 1'b0;
        cpu_req = 1'b1; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0; cpu_addr = 23'h7C0010;
        #1;
        checkOutput("abort_we_lo", 32'(mem_we_lo), 32'd0);
        checkOutput("abort_we_hi", 32'(mem_we_hi), 32'd0);
        checkOutput("abort_oe", 32'(mem_oe), 32'd0);
        checkOutput("abort_cpu_do_cleared", 32'(cpu_do), 32'd0);
        ackSeen = 0;
        repeat (2) begin
            @(posedge clk); ackSeen |= mcu_ack;
        end
        sys_rst_n = 1'b1;
        lat = 0;
        while (!cpu_dtack && lat < 100) begin
            @(posedge clk); lat++; ackSeen |= mcu_ack;
        end
        checkOutput("abort_no_ack", 32'(ackSeen), 32'd0);
        checkOutput("abort_cpu_latency", 32'(lat), 32'(MEM_CYC + 1));
        checkOutput("abort_cpu_data", 32'(cpu_do), 32'hA55A);
        cpu_req = 1'b0;
        @(posedge clk);
        checkOutput("abort_dtack_release", 32'(cpu_dtack), 32'd0);

        // Randomized traffic against the transaction-level model.
        lastCpu = 1; expCpuDo = 16'hA55A; expMcuDo = 16'h0000;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            useCpu = (mode != 1); useMcu = (mode != 0);
            cW = 1'($urandom_range(0, 1)); cBe = 2'($urandom_range(1, 3));
            cA = 23'h000100 + AW'($urandom_range(0, 7)); cD = 16'($urandom);
            mW = 1'($urandom_range(0, 1)); mBe = 2'($urandom_range(1, 3));
            mA = 23'h000100 + AW'($urandom_range(0, 7)); mD = 16'($urandom);
            fork
                begin
                    if (useCpu) runCpu(cW & cBe[0], cW & cBe[1], cA, cD, cR, cLat, cOe, cLo, cHi, cT);
                end
                begin
                    if (useMcu) runMcu(mW, mBe, mA, mD, mR, mLat, mOe, mLo, mHi, mT);
                end
            join
            cpuFirst = useCpu && (!useMcu || !lastCpu);
            for (int k = 0; k < 2; k++) begin
                if ((k == 0) == cpuFirst) begin
                    if (useCpu) begin
                        if (cW) writeRef(cA, cBe, cD);
                        else    expCpuDo = readRef(cA);
                    end
                end else if (useMcu) begin
                    if (mW) writeRef(mA, mBe, mD);
                    else    expMcuDo = readRef(mA);
                end
            end
            if (useCpu) checkOutput($sformatf("rnd%0d_cpu_do", it), 32'(cR), 32'(expCpuDo));
            if (useMcu) checkOutput($sformatf("rnd%0d_mcu_do", it), 32'(mR), 32'(expMcuDo));
            if (useCpu && useMcu) begin
                checkOutput($sformatf("rnd%0d_order", it), 32'(cpuFirst ? (cT < mT) : (mT < cT)), 32'd1);
                checkOutput($sformatf("rnd%0d_cpu_lat", it), 32'(cLat),
                            cpuFirst ? 32'(MEM_CYC + 1) : 32'(2 * (MEM_CYC + 1)));
                checkOutput($sformatf("rnd%0d_mcu_lat", it), 32'(mLat),
                            cpuFirst ? 32'(2 * (MEM_CYC + 1) + 1) : 32'(MEM_CYC + 1));
                lastCpu = !cpuFirst;
            end else if (useCpu) begin
                checkOutput($sformatf("rnd%0d_cpu_lat", it), 32'(cLat), 32'(MEM_CYC + 1));
                checkOutput($sformatf("rnd%0d_cpu_oe", it), 32'(cOe), cW ? 32'd0 : 32'(MEM_CYC));
                checkOutput($sformatf("rnd%0d_cpu_welo", it), 32'(cLo), (cW && cBe[0]) ? 32'(MEM_CYC) : 32'd0);
                checkOutput($sformatf("rnd%0d_cpu_wehi", it), 32'(cHi), (cW && cBe[1]) ? 32'(MEM_CYC) : 32'd0);
                lastCpu = 1;
            end else begin
                checkOutput($sformatf("rnd%0d_mcu_lat", it), 32'(mLat), 32'(MEM_CYC + 1));
                checkOutput($sformatf("rnd%0d_mcu_oe", it), 32'(mOe), mW ? 32'd0 : 32'(MEM_CYC));
                checkOutput($sformatf("rnd%0d_mcu_welo", it), 32'(mLo), (mW && mBe[0]) ? 32'(MEM_CYC) : 32'd0);
                checkOutput($sformatf("rnd%0d_mcu_wehi", it), 32'(mHi), (mW && mBe[1]) ? 32'(MEM_CYC) : 32'd0);
                lastCpu = 0;
            end
        end

`ifdef MAP_ARB_STAT_EN
        // CPU blocked behind an MCU access: two MCU_ACC clocks plus the IDLE grant clock.
        stat_clr = 1'b1;
        @(posedge clk);
        stat_clr = 1'b0;
        fork
            runMcu(1'b0, 2'b11, 23'h700005, 16'h0, rM, latM, oA, lA, hA, tM);
            begin
                repeat (3) @(posedge clk);
                runCpu(1'b0, 1'b0, 23'h7C0010, 16'h0, rA, latA, oA, lA, hA, tA1);
            end
        join
        checkOutput("stat_stall_count", 32'(stat_stall), 32'd3);
        stat_clr = 1'b1;
        @(posedge clk);
        stat_clr = 1'b0;
        @(posedge clk);
        checkOutput("stat_stall_clear", 32'(stat_stall), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/map_mem_arb.md
Name: map_mem_arb

Overview:
- Arbitrates the single ROM1 memory port between two requesters.
- Requester 1 is the 68k cartridge bus: already-decoded mem_ce cycles for ROM, RAM and the io buffer.
- Requester 2 is the MCU save-state/io-buffer transfer port.
- Sits between the system mapper's address decode and the mem_* bus; sequences fixed-length memory accesses and generates cpu_dtack and mcu_ack.

Parameters:
- MEM_CYC, 4: clock cycles per memory access (≥1); strobes held for this many cycles.
- AW, 23: memory address width (matches mem_addr[22:0]).

Ports:
- clk  in  1  system clock; all logic on negedge clk, as in the mapper.
- sys_rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  level; cart cycle active and decoded to memory.
- cpu_we_lo  in  1  CPU low-byte write strobe, active high.
- cpu_we_hi  in  1  CPU high-byte write strobe, active high.
- cpu_addr  in  AW  CPU memory address, already mapped.
- cpu_di  in  16  CPU write data.
- cpu_do  out  16  CPU read data, registered.
- cpu_dtack  out  1  1 = CPU cycle complete; data valid.
- mcu_req  in  1  MCU access request; held until mcu_ack.
- mcu_we  in  1  MCU write (1) / read (0).
- mcu_be  in  2  MCU byte enables, [1]=hi, [0]=lo.
- mcu_addr  in  AW  MCU address.
- mcu_di  in  16  MCU write data.
- mcu_do  out  16  MCU read data, registered.
- mcu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  AW  memory address.
- mem_di  out  16  memory write data.
- mem_do  in  16  memory read data.
- mem_oe  out  1  memory read strobe.
- mem_we_lo  out  1  memory low-byte write strobe.
- mem_we_hi  out  1  memory high-byte write strobe.

Behaviour:
- Reset (async, sys_rst_n=0):
  - state=IDLE, last_cpu=0, cyc=0.
  - All outputs 0: cpu_do, mcu_do, cpu_dtack, mcu_ack, mem_addr, mem_di, mem_oe, mem_we_lo, mem_we_hi.
  - Reset mid-access aborts immediately; strobes drop asynchronously; no ack or dtack is issued.
- States: IDLE, CPU_ACC, CPU_HOLD, MCU_ACC. Counter cyc is width clog2(MEM_CYC)+1.
- IDLE:
  - Only cpu_req: latch cpu addr/data/strobes, go CPU_ACC, last_cpu<=1.
  - Only mcu_req: latch mcu fields, go MCU_ACC, last_cpu<=0.
  - Both pending: MCU wins if last_cpu=1, else CPU wins.
- CPU_ACC:
  - mem_* driven from latched fields.
  - Read (no we strobe): mem_oe=1 for MEM_CYC cycles.
  - Write: mem_we_lo/hi = latched strobes for MEM_CYC cycles.
  - On the last cycle: cpu_do<=mem_do (reads only; unchanged on writes), cpu_dtack<=1, go CPU_HOLD.
- CPU_HOLD:
  - Strobes 0; cpu_dtack stays 1 while cpu_req=1.
  - cpu_req=0: cpu_dtack<=0, go IDLE.
  - A single CPU bus cycle never produces two memory accesses.
- MCU_ACC:
  - Same MEM_CYC timing; mem_we_hi=mcu_we&be[1], mem_we_lo=mcu_we&be[0], mem_oe=!mcu_we.
  - Last cycle: mcu_do<=mem_do on reads, mcu_ack=1 for one cycle, go IDLE.
  - If mcu_req is still high in IDLE the cycle after ack, it is a new access. Requester drops mcu_req in the ack cycle.
- Latency from request to completion, uncontended:
  - CPU: MEM_CYC+1 clocks from cpu_req to cpu_dtack.
  - MCU: MEM_CYC+1 clocks from mcu_req to mcu_ack.
  - Worst case CPU wait: one extra MCU access of MEM_CYC+1 clocks.
- Fields are latched at grant; requester input changes during an access are ignored.
- cpu_req falling during CPU_ACC: access completes; HOLD then exits on the next cycle.
- MEM_CYC=1: single-cycle strobes, still passes through HOLD.

Optional Feature:
- MAP_ARB_STAT_EN defined:
  - Adds input stat_clr (1) and output stat_stall (16).
  - stat_stall counts clocks where cpu_req=1 and state is IDLE or MCU_ACC.
  - Saturates at 16'hFFFF; synchronous clear by stat_clr, which has priority; reset 0.
- Undefined: ports and counter absent; behaviour otherwise identical.

Decomposition:
- Shared defs package (defs.v): state encodings ARB_IDLE/ARB_CPU/ARB_HOLD/ARB_MCU; `BW_ARB_ST.
- One natural sub-module: map_arb_tmr, the MEM_CYC access timer.
  - Inputs: start pulse.
  - Outputs: busy, last-cycle flag.
  - Instantiated once and shared by both access states.

Test Plan:
- CPU read uncontended:
  - Stimulus: mem model returns 16'hA55A for addr 23'h7C0010; cpu_req at T0.
  - Response: mem_oe high T1..T4; cpu_dtack=1 at T5, cpu_do=A55A; dtack drops one clock after cpu_req falls.
- MCU write, be=2'b01, data 16'h1234, addr 23'h700000:
  - Response: mem_we_lo high 4 cycles, mem_we_hi never high, mcu_ack single pulse at T5, mem_oe never high.
- Simultaneous cpu_req and mcu_req with last_cpu=0:
  - Response: CPU served first.
  - Then a CPU cycle immediately after HOLD with mcu_req still pending: MCU served before the second CPU access.
- Reset mid MCU_ACC:
  - Stimulus: assert sys_rst_n=0 in cycle 2 of the access.
  - Response: strobes 0 asynchronously, no mcu_ack, state IDLE; after release a pending cpu_req is granted normally.
- CPU cycle held 20 clocks:
  - Response: exactly one memory access; cpu_dtack remains 1 until release.
- MAP_ARB_STAT_EN:
  - Stimulus: CPU blocked behind an MCU access for 3 stall clocks, then stat_clr.
  - Response: stat_stall=3, then 0; forced saturation holds at FFFF.
